// File: rtl/sseg_scroll_pkg.sv
// Shared types and constants for the seven-segment scrolling message sequencer.
package sseg_scroll_pkg;

    localparam int unsigned MSG_DEPTH_DFLT = 16;
    localparam int unsigned POS_W          = $clog2(MSG_DEPTH_DFLT);
    localparam int unsigned TICK_W         = 26;
    localparam int unsigned SEG_W          = 8;
    localparam int unsigned BTN_N          = 3;

    localparam logic [SEG_W-1:0] BLANK_SEG = 8'hFF;

    localparam int unsigned BTN_RUN  = 0;
    localparam int unsigned BTN_STEP = 1;
    localparam int unsigned BTN_DIR  = 2;

    typedef enum logic [0:0] {
        PAUSED  = 1'b0,
        RUNNING = 1'b1
    } state_t;

    // Window position after one advance; wraps naturally at the buffer size.
    function automatic logic [POS_W-1:0] pos_step(input logic [POS_W-1:0] pos,
                                                  input logic             dir);
        return dir ? POS_W'(pos - POS_W'(1)) : POS_W'(pos + POS_W'(1));
    endfunction

endpackage

// File: rtl/sseg_scroll_ctrl_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter and a
// one-cycle press pulse on an accepted released->pressed transition.
module button_debounce
    import sseg_scroll_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             armed_q, armed_d;
    logic             press_q, press_d;

    // Synchronisers reset to "pressed" so a button held through reset never
    // looks like a fresh press; the pulse is only armed after a seen release.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b1;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            press_q <= press_d;
        end
    end

    always_comb begin
        sync1_d = btn_n;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = CNT_W'(cnt_q + CNT_W'(1));
            end
        end
        armed_d = armed_q | (sync2_q & level_q);
        press_d = armed_q & level_q & ~level_d;
    end

    assign press = press_q;

endmodule

// File: rtl/sseg_scroll_ctrl.sv
// Scrolls a 4-digit window across a 16-entry segment-pattern buffer, with
// debounced run/pause, single-step and direction buttons.
module sseg_scroll_ctrl
    import sseg_scroll_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC  = 1_000_000,
    parameter int unsigned TICK_DIV_BASE = 5_000_000,
    parameter int unsigned MSG_DEPTH     = MSG_DEPTH_DFLT
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [2:0] button,
    input  logic [2:0] switch,
    output logic [7:0] sseg0,
    output logic [7:0] sseg1,
    output logic [7:0] sseg2,
    output logic [7:0] sseg3,
    output logic [7:0] led
);

    logic [BTN_N-1:0] btn_press;

    for (genvar gi = 0; gi < BTN_N; gi++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_debounce (
            .clk   (clk_clk),
            .rst   (reset_reset),
            .btn_n (button[gi]),
            .press (btn_press[gi])
        );
    end

    logic             run_p, step_p, dir_p;
    assign run_p  = btn_press[BTN_RUN];
    assign step_p = btn_press[BTN_STEP];
    assign dir_p  = btn_press[BTN_DIR];

    logic [SEG_W-1:0]  msg_q [MSG_DEPTH];
    logic [SEG_W-1:0]  msg_d [MSG_DEPTH];
    state_t            state_q, state_d;
    logic [TICK_W-1:0] cnt_q,   cnt_d;
    logic [POS_W-1:0]  pos_q,   pos_d;
    logic              dir_q,   dir_d;
    logic [SEG_W-1:0]  sseg0_q, sseg0_d;
    logic [SEG_W-1:0]  sseg1_q, sseg1_d;
    logic [SEG_W-1:0]  sseg2_q, sseg2_d;
    logic [SEG_W-1:0]  sseg3_q, sseg3_d;
    logic [7:0]        led_q,   led_d;

    logic [TICK_W-1:0] period_m1_c;
    logic              tick_c;
    logic              advance_c;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int i = 0; i < int'(MSG_DEPTH); i++) begin
                msg_q[i] <= BLANK_SEG;
            end
            state_q <= PAUSED;
            cnt_q   <= '0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            sseg0_q <= BLANK_SEG;
            sseg1_q <= BLANK_SEG;
            sseg2_q <= BLANK_SEG;
            sseg3_q <= BLANK_SEG;
            led_q   <= 8'h00;
        end else begin
            msg_q   <= msg_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            sseg0_q <= sseg0_d;
            sseg1_q <= sseg1_d;
            sseg2_q <= sseg2_d;
            sseg3_q <= sseg3_d;
            led_q   <= led_d;
        end
    end

    // The >= compare lets a shortened period take effect without waiting for a wrap.
    always_comb begin
        period_m1_c = TICK_W'((TICK_W'(switch) + TICK_W'(1)) * TICK_W'(TICK_DIV_BASE)
                              - TICK_W'(1));
        tick_c      = (state_q == RUNNING) && (cnt_q >= period_m1_c);
    end

    // FSM, tick counter and window position; a run pulse on a tick cycle suppresses the advance.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        advance_c = 1'b0;
        case (state_q)
            PAUSED: begin
                if (step_p) begin
                    advance_c = 1'b1;
                end
                if (run_p) begin
                    state_d = RUNNING;
                    cnt_d   = '0;
                end
            end
            RUNNING: begin
                cnt_d = tick_c ? '0 : TICK_W'(cnt_q + TICK_W'(1));
                if (run_p) begin
                    state_d = PAUSED;
                end else if (tick_c) begin
                    advance_c = 1'b1;
                end
            end
            default: begin
                state_d = PAUSED;
                cnt_d   = '0;
            end
        endcase
        pos_d = advance_c ? pos_step(pos_q, dir_q) : pos_q;
        dir_d = dir_q ^ dir_p;
    end

    always_comb begin
        msg_d = msg_q;
        if (wr_en) begin
            msg_d[wr_addr] = wr_data;
        end
    end

    always_comb begin
        sseg0_d = msg_q[pos_q];
        sseg1_d = msg_q[POS_W'(pos_q + POS_W'(1))];
        sseg2_d = msg_q[POS_W'(pos_q + POS_W'(2))];
        sseg3_d = msg_q[POS_W'(pos_q + POS_W'(3))];
        led_d   = {2'b00, dir_q, (state_q == RUNNING), pos_q};
    end

    assign sseg0 = sseg0_q;
    assign sseg1 = sseg1_q;
    assign sseg2 = sseg2_q;
    assign sseg3 = sseg3_q;
    assign led   = led_q;

endmodule

// File: tb/tb_sseg_scroll_ctrl.sv
// Directed bench for sseg_scroll_ctrl with short debounce and tick periods.
module tb_sseg_scroll_ctrl;

    logic       clk_clk;
    logic       reset_reset;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] button;
    logic [2:0] switch;
    logic [7:0] sseg0, sseg1, sseg2, sseg3;
    logic [7:0] led;

    int n_chk  = 0;
    int n_pass = 0;

    sseg_scroll_ctrl #(
        .DEBOUNCE_CYC  (4),
        .TICK_DIV_BASE (10),
        .MSG_DEPTH     (16)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .button      (button),
        .switch      (switch),
        .sseg0       (sseg0),
        .sseg1       (sseg1),
        .sseg2       (sseg2),
        .sseg3       (sseg3),
        .led         (led)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_sseg(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
        check({tag, ".sseg0"}, sseg0, e0);
        check({tag, ".sseg1"}, sseg1, e1);
        check({tag, ".sseg2"}, sseg2, e2);
        check({tag, ".sseg3"}, sseg3, e3);
    endtask

    // Press is consumed 7 edges after it is driven; all outputs settle by edge 8.
    task automatic press(input int idx);
        button[idx] = 1'b0;
        step(8);
        button[idx] = 1'b1;
        step(8);
    endtask

    task automatic write_all;
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_addr = 4'(i);
            wr_data = 8'(i);
            step(1);
        end
        wr_en = 1'b0;
    endtask

    initial begin
        reset_reset = 1'b1;
        wr_en       = 1'b0;
        wr_addr     = 4'h0;
        wr_data     = 8'h00;
        button      = 3'b111;
        switch      = 3'd0;

        // 1. Reset values, then fill the buffer with its own indices
        step(2);
        check_sseg("reset", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        check("reset.led", led, 8'h00);
        reset_reset = 1'b0;
        write_all();
        step(1);
        check_sseg("fill", 8'h00, 8'h01, 8'h02, 8'h03);
        check("fill.led", led, 8'h00);

        // 2. Bouncy run press: short runs are rejected, one pulse, tick every 10 cycles
        button[0] = 1'b0; step(3);
        button[0] = 1'b1; step(1);
        button[0] = 1'b0; step(3);
        button[0] = 1'b1; step(1);
        button[0] = 1'b0;
        step(8);
        check("run.start.led", led, 8'h10);
        step(9);
        check("run.pre_tick1.led", led, 8'h10);
        step(1);
        check("run.tick1.led", led, 8'h11);
        check("run.tick1.sseg0", sseg0, 8'h01);
        step(9);
        check("run.pre_tick2.led", led, 8'h11);
        step(1);
        check("run.tick2.led", led, 8'h12);
        check("run.tick2.sseg0", sseg0, 8'h02);
        button[0] = 1'b1;

        // 3. Step wrap in both directions from a fresh reset
        reset_reset = 1'b1;
        step(2);
        reset_reset = 1'b0;
        write_all();
        step(1);
        press(2);
        press(1);
        press(2);
        check("step.back.led", led, 8'h0F);
        check_sseg("step.back", 8'h0F, 8'h00, 8'h01, 8'h02);
        press(1);
        check("step.wrap.led", led, 8'h00);
        check_sseg("step.wrap", 8'h00, 8'h01, 8'h02, 8'h03);
        press(2);
        press(1);
        check("step.dir.led", led, 8'h2F);

        // 4. Period 40, then lower to 10 mid-count: tick on the next edge
        switch = 3'd3;
        press(0);
        check("slow.run.led", led, 8'h3F);
        step(10);
        switch = 3'd0;
        step(1);
        check("speed.lag.led", led, 8'h3F);
        step(1);
        check("speed.tick.led", led, 8'h3E);
        check("speed.tick.sseg0", sseg0, 8'h0E);
        check("speed.tick.sseg1", sseg1, 8'h0F);
        check("speed.tick.sseg2", sseg2, 8'h00);
        step(9);
        check("speed.pre_tick.led", led, 8'h3E);
        step(1);
        check("speed.period10.led", led, 8'h3D);

        // 5. Run pulse lands on the tick edge: pause wins, no advance
        step(2);
        button[0] = 1'b0;
        step(8);
        check("collide.led", led, 8'h2D);
        button[0] = 1'b1;
        step(10);
        check("collide.hold.led", led, 8'h2D);
        wr_en   = 1'b1;
        wr_addr = 4'd14;
        wr_data = 8'h55;
        step(1);
        wr_en = 1'b0;
        check("write.lag.sseg1", sseg1, 8'h0E);
        step(1);
        check("write.sseg1", sseg1, 8'h55);

        // 6. Reset mid-run with run held: no pulse until release and re-press
        press(0);
        check("rerun.led", led, 8'h3D);
        button[0] = 1'b0;
        step(3);
        reset_reset = 1'b1;
        step(2);
        check_sseg("midreset", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        check("midreset.led", led, 8'h00);
        reset_reset = 1'b0;
        step(20);
        check("held.led", led, 8'h00);
        check("held.sseg0", sseg0, 8'hFF);
        button[0] = 1'b1;
        step(10);
        press(0);
        check("repress.led", led, 8'h10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
